// File: rtl/hs_unit_pkg.sv
// Shared types for the handshake-unit blocks: skid buffer FSM state encoding.
package hs_unit_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } hs_skid_state_e;

endpackage

// File: rtl/hs_unit_skid_buffer.sv
// Two-entry valid/ready register slice; m_data, m_valid and s_ready all come straight from flops.
// Define HS_UNIT_SKID_ASSERT_EN to compile in handshake-stability and state-encoding SVA.
module hs_unit_skid_buffer
  import hs_unit_pkg::*;
#(
  parameter type DATA_TYPE = logic
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     s_valid,
  output logic     s_ready,
  input  DATA_TYPE s_data,
  output logic     m_valid,
  input  logic     m_ready,
  output DATA_TYPE m_data
);

  hs_skid_state_e state;
  DATA_TYPE       skid;
  logic           in_xfer, out_xfer;

  assign in_xfer  = s_valid & s_ready & ~rst;
  assign out_xfer = m_valid & m_ready & ~rst;

  // Flags are written alongside the state so they always match its decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      m_valid <= 1'b0;
      s_ready <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          s_ready <= 1'b1;
          if (in_xfer) begin
            state   <= BUSY;
            m_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (in_xfer && !out_xfer) begin
            state   <= FULL;
            s_ready <= 1'b0;
          end else if (out_xfer && !in_xfer) begin
            state   <= EMPTY;
            m_valid <= 1'b0;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state   <= BUSY;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          m_valid <= 1'b0;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

  // Data registers carry no reset; validity is tracked by the FSM alone.
  always_ff @(posedge clk) begin
    case (state)
      EMPTY: if (in_xfer) m_data <= s_data;
      BUSY: begin
        if (in_xfer && out_xfer) m_data <= s_data;
        else if (in_xfer)        skid   <= s_data;
      end
      FULL: if (out_xfer) m_data <= skid;
      default: ;
    endcase
  end

`ifdef HS_UNIT_SKID_ASSERT_EN
  a_s_stable: assert property (@(posedge clk) disable iff (rst)
    (s_valid && !s_ready) |=> (s_valid && $stable(s_data)));
  a_m_stable: assert property (@(posedge clk) disable iff (rst)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));
  a_state_legal: assert property (@(posedge clk) disable iff (rst)
    (logic'(state[1] & state[0]) == 1'b0));
`else
`endif

endmodule

// File: tb/tb_hs_unit_skid_buffer.sv
// Directed + random scoreboard bench for hs_unit_skid_buffer (8-bit payload).
module tb_hs_unit_skid_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_ready, m_valid, m_ready;
  logic [7:0] s_data, m_data;

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [7:0] q[$];
  logic       exp_srdy;

  hs_unit_skid_buffer #(.DATA_TYPE(logic [7:0])) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called at a negedge: drive, check outputs against the model, advance one clock.
  task automatic cyc(input logic v, input logic [7:0] d, input logic mr);
    logic in_x, out_x;
    s_valid = v; s_data = d; m_ready = mr; rst = 1'b0;
    chk("s_ready", 8'(s_ready), 8'(exp_srdy));
    chk("m_valid", 8'(m_valid), 8'(q.size() > 0));
    if (q.size() > 0) chk("m_data", m_data, q[0]);
    in_x  = v & exp_srdy;
    out_x = mr & (q.size() > 0);
    if (out_x) void'(q.pop_front());
    if (in_x)  q.push_back(d);
    @(posedge clk);
    exp_srdy = (q.size() < 2);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b1; s_data = 8'hEE; m_ready = 1'b1;
    @(posedge clk);
    q.delete();
    exp_srdy = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", 8'(m_valid), 8'h00);
    chk("rst_s_ready", 8'(s_ready), 8'h00);
  endtask

  initial begin
    logic       v;
    logic [7:0] d;
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0; exp_srdy = 1'b0;
    @(negedge clk);
    do_reset();

    // First beat after reset: s_ready rises on the first edge, A5 appears one cycle after acceptance.
    cyc(1'b1, 8'hA5, 1'b1);
    chk("srdy_after_rst", 8'(s_ready), 8'h01);
    cyc(1'b1, 8'hA5, 1'b1);
    chk("first_m_data", m_data, 8'hA5);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);

    // Streaming 0..15 at full rate.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);

    // Backpressure: 0x11 in main, 0x12 in skid.
    cyc(1'b1, 8'h10, 1'b1);
    cyc(1'b1, 8'h11, 1'b1);
    cyc(1'b1, 8'h12, 1'b0);
    cyc(1'b1, 8'h13, 1'b0);
    chk("bp_full_srdy", 8'(s_ready), 8'h00);
    chk("bp_main", m_data, 8'h11);
    cyc(1'b1, 8'h13, 1'b1);
    chk("bp_skid_out", m_data, 8'h12);
    chk("bp_srdy_back", 8'(s_ready), 8'h01);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);

    // Random traffic, holding a stalled beat stable.
    v = 1'b0; d = 8'h00;
    for (int i = 0; i < 10000; i++) begin
      if (!(v && !exp_srdy)) begin
        v = 1'($urandom_range(0, 1));
        d = 8'($urandom);
      end
      cyc(v, d, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("drain_empty", 8'(m_valid), 8'h00);

    // Reset while FULL discards both beats.
    cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'h66, 1'b0);
    chk("pre_rst_full", 8'(s_ready), 8'h00);
    do_reset();
    cyc(1'b0, 8'h00, 1'b1);
    chk("post_rst_srdy", 8'(s_ready), 8'h01);
    chk("post_rst_no_stale", 8'(m_valid), 8'h00);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h77, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
